// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game-logic sequencer: on each frame_tick advances the game FSM,
// bird physics, pipe scroll/respawn, collision detection and scoring.
`timescale 1ns/1ps
module flappy_game_ctrl #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BIRD_X     = 160,
  parameter int BIRD_W     = 16,
  parameter int BIRD_H     = 16,
  parameter int PIPE_W     = 32,
  parameter int GAP_H      = 128,
  parameter int GAP_MIN    = 64,
  parameter int START_Y    = 224,
  parameter int GRAVITY    = 1,
  parameter int FLAP_VEL   = 8,
  parameter int VMAX       = 12,
  parameter int PIPE_SPEED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] game_state,
  output logic [8:0] bird_y,
  output logic [9:0] pipe_x,
  output logic [8:0] gap_y,
  output logic [7:0] score,
  output logic [7:0] hi_score,
  output logic       update_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_DYING = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  localparam logic signed [10:0] FLOOR_Y    = 11'(SCREEN_H - BIRD_H);
  localparam logic [8:0]         FLOOR_Y9   = 9'(SCREEN_H - BIRD_H);
  localparam logic [8:0]         START_Y9   = 9'(START_Y);
  localparam logic [8:0]         GAP_RST    = 9'd176;
  localparam logic [8:0]         GAP_MIN9   = 9'(GAP_MIN);
  localparam logic [9:0]         SCREEN_W10 = 10'(SCREEN_W);
  localparam logic [9:0]         SPEED10    = 10'(PIPE_SPEED);
  localparam logic [10:0]        BIRD_X11   = 11'(BIRD_X);
  localparam logic [10:0]        BIRD_END11 = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0]        BIRD_H11   = 11'(BIRD_H);
  localparam logic [10:0]        PIPE_W11   = 11'(PIPE_W);
  localparam logic [10:0]        GAP_H11    = 11'(GAP_H);
  localparam logic signed [5:0]  GRAV_V     = 6'(GRAVITY);
  localparam logic signed [5:0]  FLAP_V     = 6'(-FLAP_VEL);
  localparam logic signed [5:0]  VMAX_V     = 6'(VMAX);

  logic [1:0] up_sync_q, dn_sync_q;
  logic       up_prev_q;
  logic       flap_req_q;
  logic [7:0] lfsr_q;
  logic       up_rise, flap_now, down_now;

  state_e            state_q, state_d;
  logic [8:0]        bird_y_q, bird_y_d;
  logic signed [5:0] vel_q, vel_d;
  logic [9:0]        pipe_x_q, pipe_x_d;
  logic [8:0]        gap_y_q, gap_y_d;
  logic [7:0]        score_q, score_d;
  logic [7:0]        hi_q, hi_d;
  logic              update_done_q;

  logic signed [5:0]  vel_sum;
  logic signed [10:0] y_new;
  logic [10:0]        px_new;
  logic               hit_pipe, passed;

  // A press landing in the tick cycle itself still counts for that frame.
  assign up_rise  = up_sync_q[1] & ~up_prev_q;
  assign flap_now = flap_req_q | up_rise;
  assign down_now = dn_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync_q  <= '0;
      dn_sync_q  <= '0;
      up_prev_q  <= 1'b0;
      flap_req_q <= 1'b0;
      lfsr_q     <= 8'hA5;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      up_sync_q <= {up_sync_q[0], btn_up};
      dn_sync_q <= {dn_sync_q[0], btn_down};
      up_prev_q <= up_sync_q[1];
      lfsr_q    <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (frame_tick)   flap_req_q <= 1'b0;
      else if (up_rise) flap_req_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no branch can infer a latch.
    state_d  = state_q;
    bird_y_d = bird_y_q;
    vel_d    = vel_q;
    pipe_x_d = pipe_x_q;
    gap_y_d  = gap_y_q;
    score_d  = score_q;
    hi_d     = hi_q;
    vel_sum  = '0;
    y_new    = '0;
    px_new   = '0;
    hit_pipe = 1'b0;
    passed   = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        S_IDLE: begin
          bird_y_d = START_Y9;
          vel_d    = '0;
          pipe_x_d = SCREEN_W10;
          if (flap_now) begin
            state_d = S_PLAY;
            score_d = '0;
          end
        end
        S_PLAY: begin
          if (flap_now) begin
            vel_d = FLAP_V;
          end else begin
            vel_sum = vel_q + GRAV_V + (down_now ? GRAV_V : 6'sd0);
            vel_d   = (vel_sum > VMAX_V) ? VMAX_V : vel_sum;
          end
          y_new = $signed({2'b00, bird_y_q}) + $signed({{5{vel_d[5]}}, vel_d});
          if (pipe_x_q < SPEED10) begin
            pipe_x_d = SCREEN_W10;
            gap_y_d  = GAP_MIN9 + {1'b0, lfsr_q};
          end else begin
            pipe_x_d = pipe_x_q - SPEED10;
          end
          if (y_new[10]) begin
            bird_y_d = '0;
            state_d  = S_DYING;
          end else if (y_new >= FLOOR_Y) begin
            bird_y_d = FLOOR_Y9;
            state_d  = S_OVER;
          end else begin
            bird_y_d = y_new[8:0];
          end
          // Collision and scoring both look at the already-updated positions.
          px_new   = {1'b0, pipe_x_d};
          hit_pipe = (px_new < BIRD_END11) && (px_new + PIPE_W11 > BIRD_X11) &&
                     ((bird_y_d < gap_y_d) ||
                      ({2'b00, bird_y_d} + BIRD_H11 > {2'b00, gap_y_d} + GAP_H11));
          passed   = ({1'b0, pipe_x_q} + PIPE_W11 >= BIRD_X11) && (px_new + PIPE_W11 < BIRD_X11);
          if (state_d == S_PLAY) begin
            if (hit_pipe)                           state_d = S_DYING;
            else if (passed && score_q != 8'hFF)    score_d = score_q + 8'd1;
          end
        end
        S_DYING: begin
          vel_sum = vel_q + GRAV_V;
          vel_d   = (vel_sum > VMAX_V) ? VMAX_V : vel_sum;
          y_new   = $signed({2'b00, bird_y_q}) + $signed({{5{vel_d[5]}}, vel_d});
          if (y_new >= FLOOR_Y) begin
            bird_y_d = FLOOR_Y9;
            state_d  = S_OVER;
          end else if (y_new[10]) begin
            bird_y_d = '0;
          end else begin
            bird_y_d = y_new[8:0];
          end
        end
        S_OVER: begin
          if (flap_now) begin
            state_d  = S_IDLE;
            bird_y_d = START_Y9;
            vel_d    = '0;
            pipe_x_d = SCREEN_W10;
          end
        end
      endcase
      if (state_d == S_OVER && state_q != S_OVER)
        hi_d = (score_d > hi_q) ? score_d : hi_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bird_y_q      <= START_Y9;
      vel_q         <= '0;
      pipe_x_q      <= SCREEN_W10;
      gap_y_q       <= GAP_RST;
      score_q       <= '0;
      hi_q          <= '0;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bird_y_q      <= bird_y_d;
      vel_q         <= vel_d;
      pipe_x_q      <= pipe_x_d;
      gap_y_q       <= gap_y_d;
      score_q       <= score_d;
      hi_q          <= hi_d;
      update_done_q <= frame_tick;
    end
  end

  assign game_state  = state_q;
  assign bird_y      = bird_y_q;
  assign pipe_x      = pipe_x_q;
  assign gap_y       = gap_y_q;
  assign score       = score_q;
  assign hi_score    = hi_q;
  assign update_done = update_done_q;

endmodule
